// File: rtl/cmos_pkg.sv
// Shared types and defaults for the CMOS RGB565 capture stage.
package cmos_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam int H_ACTIVE_DEF    = 640;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int SKIP_FRAMES_DEF = 10;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int PIX_W = R_W + G_W + B_W;

  localparam int X_W = 11;
  localparam int Y_W = 10;

endpackage

// File: rtl/cmos_edge_det.sv
// Registers a 1-bit sensor input and flags its rising and falling edges.
module cmos_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_d;

  // Input register plus one delayed copy for edge comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/cmos_rgb565_capture.sv
// Assembles the sensor byte stream into RGB565 pixels with frame framing,
// start-up frame skipping, pixel coordinates and a frame-geometry check.
//
// state  | meaning
// SETTLE | discarding frames after reset while the sensor settles
// SYNC   | waiting for vsync to fall so a frame can start
// ACTIVE | capturing pixels of the current frame
module cmos_rgb565_capture
  import cmos_pkg::*;
#(
  parameter int SKIP_FRAMES = SKIP_FRAMES_DEF,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF
) (
  input  logic             cmos_pclk,
  input  logic             rst,
  input  logic             cmos_vsync,
  input  logic             cmos_href,
  input  logic [7:0]       cmos_data,
  output logic [PIX_W-1:0] rgb_out,
  output logic             rgb_data_valid,
  output logic             rgb_fram_valid,
  output logic [X_W-1:0]   rgb_x,
  output logic [Y_W-1:0]   rgb_y,
  output logic             frame_err
);

  logic           vs_level_unused;  // only vsync edges drive the logic
  logic           vs_rise, vs_fall;
  logic           hs_r, hs_fall, hs_rise_unused;
  logic [7:0]     d_r;
  logic [7:0]     hi;
  logic           phase;
  logic           line_any;
  logic           bad_frame;
  logic [31:0]    skip_cnt;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  state_t         state;

  logic           line_end;
  logic           line_bad;
  logic [Y_W-1:0] y_next;
  logic           frame_bad;

  cmos_edge_det u_vs (
    .clk  (cmos_pclk),
    .rst  (rst),
    .d    (cmos_vsync),
    .q    (vs_level_unused),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  cmos_edge_det u_hs (
    .clk  (cmos_pclk),
    .rst  (rst),
    .d    (cmos_href),
    .q    (hs_r),
    .rise (hs_rise_unused),
    .fall (hs_fall)
  );

  // Data byte register, aligned with the registered href/vsync copies.
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) d_r <= 8'd0;
    else     d_r <= cmos_data;
  end

  // Line and frame checks; a line ending together with vsync rise is
  // folded into the closing frame's verdict.
  always_comb begin
    line_end  = hs_fall && (state == ACTIVE) && line_any;
    line_bad  = (x_cnt != X_W'(H_ACTIVE)) || phase;
    y_next    = y_cnt;
    if (line_end && (y_cnt != {Y_W{1'b1}})) y_next = y_cnt + 1'b1;
    frame_bad = bad_frame || (line_end && line_bad) ||
                (y_next != Y_W'(V_ACTIVE));
  end

  // Framing FSM with byte pairing, counters and registered outputs.
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      state          <= SETTLE;
      skip_cnt       <= 32'd0;
      hi             <= 8'd0;
      phase          <= 1'b0;
      line_any       <= 1'b0;
      bad_frame      <= 1'b0;
      x_cnt          <= '0;
      y_cnt          <= '0;
      rgb_out        <= '0;
      rgb_data_valid <= 1'b0;
      rgb_fram_valid <= 1'b0;
      rgb_x          <= '0;
      rgb_y          <= '0;
      frame_err      <= 1'b0;
    end else begin
      rgb_data_valid <= 1'b0;
      frame_err      <= 1'b0;
      case (state)
        SETTLE: begin
          if (vs_rise) begin
            if (skip_cnt + 32'd1 >= 32'(SKIP_FRAMES)) state <= SYNC;
            else skip_cnt <= skip_cnt + 32'd1;
          end
        end
        SYNC: begin
          if (vs_fall) begin
            state          <= ACTIVE;
            rgb_fram_valid <= 1'b1;
            x_cnt          <= '0;
            y_cnt          <= '0;
            phase          <= 1'b0;
            line_any       <= 1'b0;
            bad_frame      <= 1'b0;
          end
        end
        ACTIVE: begin
          if (hs_r) begin
            line_any <= 1'b1;
            phase    <= ~phase;
            if (!phase) begin
              hi <= d_r;
            end else begin
              rgb_out        <= {hi, d_r};
              rgb_data_valid <= 1'b1;
              rgb_x          <= x_cnt;
              rgb_y          <= y_cnt;
              if (x_cnt != {X_W{1'b1}}) x_cnt <= x_cnt + 1'b1;
            end
          end else begin
            phase <= 1'b0;
          end
          if (line_end) begin
            x_cnt    <= '0;
            y_cnt    <= y_next;
            line_any <= 1'b0;
            if (line_bad) bad_frame <= 1'b1;
          end
          if (vs_rise) begin
            state          <= SYNC;
            rgb_fram_valid <= 1'b0;
            frame_err      <= frame_bad;
            bad_frame      <= 1'b0;
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_rgb565_capture.sv
// Scoreboard bench for cmos_rgb565_capture with a small frame geometry.
module tb_cmos_rgb565_capture;

  localparam int H = 4;
  localparam int V = 2;
  localparam int SKIP = 1;

  logic        cmos_pclk = 1'b0;
  logic        rst = 1'b1;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_data = 8'd0;
  logic [15:0] rgb_out;
  logic        rgb_data_valid;
  logic        rgb_fram_valid;
  logic [10:0] rgb_x;
  logic [9:0]  rgb_y;
  logic        frame_err;

  cmos_rgb565_capture #(
    .SKIP_FRAMES (SKIP),
    .H_ACTIVE    (H),
    .V_ACTIVE    (V)
  ) dut (
    .cmos_pclk      (cmos_pclk),
    .rst            (rst),
    .cmos_vsync     (cmos_vsync),
    .cmos_href      (cmos_href),
    .cmos_data      (cmos_data),
    .rgb_out        (rgb_out),
    .rgb_data_valid (rgb_data_valid),
    .rgb_fram_valid (rgb_fram_valid),
    .rgb_x          (rgb_x),
    .rgb_y          (rgb_y),
    .frame_err      (frame_err)
  );

  always #5 cmos_pclk = ~cmos_pclk;

  typedef struct {
    logic [15:0] pix;
    int          x;
    int          y;
    int          at;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   err_cnt = 0;
  logic fv_prev = 1'b0;
  logic [7:0] tbl [8] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};

  always @(posedge cmos_pclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on each pixel, tracks frame_err.
  initial begin
    exp_t e;
    forever begin
      @(negedge cmos_pclk);
      if (!rst) begin
        if (rgb_data_valid) begin
          chk("pix_expected", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("pix", int'(rgb_out), int'(e.pix));
            chk("pix_x", int'(rgb_x), e.x);
            chk("pix_y", int'(rgb_y), e.y);
            chk("pix_lat", cyc, e.at);
          end
        end
        if (frame_err) begin
          err_cnt++;
          chk("ferr_with_fv_fall", int'({fv_prev, rgb_fram_valid}), 2);
        end
      end
      fv_prev = rgb_fram_valid;
    end
  end

  task automatic tick();
    @(posedge cmos_pclk);
    #1;
  endtask

  task automatic send_line(input int nbytes, input bit cap, input int y,
                           input bit end_frame, input bit use_tbl);
    logic [7:0] hi, b;
    hi = 8'd0;
    for (int i = 0; i < nbytes; i++) begin
      tick();
      b = use_tbl ? tbl[i % 8] : 8'($urandom);
      cmos_href = 1'b1;
      cmos_data = b;
      if (i % 2 == 0) hi = b;
      else if (cap) q.push_back('{{hi, b}, i / 2, y, cyc + 2});
    end
    tick();
    cmos_href = 1'b0;
    cmos_data = 8'd0;
    if (end_frame) cmos_vsync = 1'b1;
    else repeat (4) tick();
  endtask

  task automatic frame(input string tag, input bit cap, input int nlines,
                       input int lb0, input int lb1, input int lb2,
                       input bit tbl0, input bit coincide, input int exp_err);
    int e0, nb;
    e0 = err_cnt;
    for (int l = 0; l < nlines; l++) begin
      nb = (l == 0) ? lb0 : (l == 1) ? lb1 : lb2;
      send_line(nb, cap, l, coincide && (l == nlines - 1), tbl0 && (l == 0));
      if (l == 0) chk({tag, "_fram_valid"}, int'(rgb_fram_valid), int'(cap));
    end
    if (!coincide) begin
      tick();
      cmos_vsync = 1'b1;
    end
    repeat (3) tick();
    cmos_vsync = 1'b0;
    repeat (6) tick();
    chk({tag, "_frame_err"}, err_cnt - e0, exp_err);
    chk({tag, "_q_empty"}, q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_rgb_out", int'(rgb_out), 0);
    chk("rst_valid", int'(rgb_data_valid), 0);
    chk("rst_fram_valid", int'(rgb_fram_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    rst = 1'b0;
    repeat (4) tick();

    frame("skip",   0, 2, 8, 8, 0, 0, 0, 0);
    frame("order",  1, 2, 8, 8, 0, 1, 0, 0);
    frame("short",  1, 2, 8, 6, 0, 0, 0, 1);
    frame("good",   1, 2, 8, 8, 0, 0, 0, 0);
    frame("odd",    1, 2, 9, 8, 0, 0, 0, 1);
    frame("lines3", 1, 3, 8, 8, 8, 0, 0, 1);
    frame("coin2",  1, 2, 8, 8, 0, 0, 1, 0);
    frame("coin3",  1, 3, 8, 8, 8, 0, 1, 1);

    // Reset in the middle of a captured line.
    tick();
    cmos_href = 1'b1;
    cmos_data = 8'hA5;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_rgb_out", int'(rgb_out), 0);
    chk("mid_rst_x", int'(rgb_x), 0);
    chk("mid_rst_y", int'(rgb_y), 0);
    chk("mid_rst_valid", int'(rgb_data_valid), 0);
    chk("mid_rst_fram_valid", int'(rgb_fram_valid), 0);
    chk("mid_rst_frame_err", int'(frame_err), 0);
    q.delete();
    cmos_href = 1'b0;
    cmos_data = 8'd0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();

    frame("rst_skip", 0, 2, 8, 8, 0, 0, 0, 0);
    frame("rst_good", 1, 2, 8, 8, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
